// File: rtl/ram_dp_rw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_dp_rw_ctrl                                            |
// | Brief    : Request-side controller for a true-dual-port RAM wrapper. |
// |            Two valid/ready request ports (A, B), each carrying a     |
// |            read or a write. Cross-port address collisions are        |
// |            arbitrated with a toggling priority. Read latency is      |
// |            tracked by a tag pipe, and read data is returned in order |
// |            through a per-port response FIFO guarded by read credits. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ram_dp_rw_ctrl #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32,
    parameter int Pipelined = 0,
    parameter int RspDepth  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // request port A
    input  logic                 req_valid_a_i,
    output logic                 req_ready_a_o,
    input  logic                 req_we_a_i,
    input  logic [AddrWidth-1:0] req_addr_a_i,
    input  logic [DataWidth-1:0] req_wdata_a_i,
    // request port B
    input  logic                 req_valid_b_i,
    output logic                 req_ready_b_o,
    input  logic                 req_we_b_i,
    input  logic [AddrWidth-1:0] req_addr_b_i,
    input  logic [DataWidth-1:0] req_wdata_b_i,
    // response port A
    output logic                 rsp_valid_a_o,
    input  logic                 rsp_ready_a_i,
    output logic [DataWidth-1:0] rsp_rdata_a_o,
    // response port B
    output logic                 rsp_valid_b_o,
    input  logic                 rsp_ready_b_i,
    output logic [DataWidth-1:0] rsp_rdata_b_o,
    // RAM side, port A
    output logic                 ram_rd_en_a_o,
    output logic                 ram_wr_en_a_o,
    output logic [AddrWidth-1:0] ram_addr_r_a_o,
    output logic [AddrWidth-1:0] ram_addr_w_a_o,
    output logic [DataWidth-1:0] ram_wdata_a_o,
    input  logic [DataWidth-1:0] ram_rdata_a_i,
    // RAM side, port B
    output logic                 ram_rd_en_b_o,
    output logic                 ram_wr_en_b_o,
    output logic [AddrWidth-1:0] ram_addr_r_b_o,
    output logic [AddrWidth-1:0] ram_addr_w_b_o,
    output logic [DataWidth-1:0] ram_wdata_b_o,
    input  logic [DataWidth-1:0] ram_rdata_b_i
);

    // Read latency of the attached RAM; RspDepth must be at least c_LAT + 2
    // for one read per cycle to sustain with the consumer always ready.
    localparam int c_LAT = 1 + Pipelined;
    localparam int c_CW  = $clog2(RspDepth + 1);
    localparam int c_PW  = $clog2(RspDepth);
    localparam int c_SW  = c_CW + 1;

    // Both ports gathered into index 0 (A) / 1 (B) so the per-port logic is shared.
    logic [1:0]           w_valid;
    logic [1:0]           w_we;
    logic [1:0]           w_rsp_ready;
    logic [AddrWidth-1:0] w_addr      [2];
    logic [DataWidth-1:0] w_ram_rdata [2];
    logic [DataWidth-1:0] w_rsp_rdata [2];

    logic [1:0] w_credit;
    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic [1:0] w_accept;
    logic [1:0] w_rd_issue;
    logic [1:0] w_wr_issue;
    logic [1:0] w_rsp_valid;
    logic       w_conflict;
    logic       w_same_addr;
    logic [AddrWidth-1:0] w_addr_gate;
    logic [DataWidth-1:0] w_data_gate;

    logic       r_prio;

    assign w_valid     = {req_valid_b_i, req_valid_a_i};
    assign w_we        = {req_we_b_i, req_we_a_i};
    assign w_rsp_ready = {rsp_ready_b_i, rsp_ready_a_i};
    assign w_addr[0]   = req_addr_a_i;
    assign w_addr[1]   = req_addr_b_i;
    assign w_ram_rdata[0] = ram_rdata_a_i;
    assign w_ram_rdata[1] = ram_rdata_b_i;

    // Writes never need credit; reads need room in inflight + FIFO.
    assign w_elig = w_we | w_credit;

    // A collision exists only when both requests could actually go and at
    // least one of them writes; two reads of one address are harmless.
    assign w_same_addr = (w_addr[0] == w_addr[1]);
    assign w_conflict  = (&w_valid) & (&w_elig) & w_same_addr & (|w_we);

    assign w_grant[0] = ~w_conflict | ~r_prio;
    assign w_grant[1] = ~w_conflict |  r_prio;

    // Nothing is offered while reset is held so every output stays at zero.
    assign w_ready    = {2{rst_ni}} & w_elig & w_grant;
    assign w_accept   = w_valid & w_ready;
    assign w_rd_issue = w_accept & ~w_we;
    assign w_wr_issue = w_accept &  w_we;

    // Priority flips only on a cycle that actually had to pick a winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio <= 1'b0;
        end else if (w_conflict) begin
            r_prio <= ~r_prio;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [c_CW-1:0]      r_inflight;
        logic [c_CW-1:0]      r_occ;
        logic [c_LAT-1:0]     r_tag;
        logic [c_PW-1:0]      r_wr_ptr;
        logic [c_PW-1:0]      r_rd_ptr;
        logic [DataWidth-1:0] r_mem [RspDepth];
        logic [c_SW-1:0]      w_used;
        logic                 w_push;
        logic                 w_pop;
        logic                 w_has_data;

        assign w_used      = {1'b0, r_inflight} + {1'b0, r_occ};
        assign w_credit[p] = (w_used < c_SW'(RspDepth));
        assign w_push      = r_tag[c_LAT-1];
        assign w_has_data  = (r_occ != '0);
        assign w_pop       = w_has_data & w_rsp_ready[p];

        assign w_rsp_valid[p] = w_has_data;
        assign w_rsp_rdata[p] = w_has_data ? r_mem[r_rd_ptr] : '0;

        // Reads that have left for the RAM but whose data is not yet in the FIFO.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= r_inflight + c_CW'(w_rd_issue[p]) - c_CW'(w_push);
            end
        end

        // Tag pipe: a bit leaves the last stage exactly when the RAM data is valid.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_tag <= '0;
            end else begin
                r_tag[0] <= w_rd_issue[p];
                for (int i = 1; i < c_LAT; i++) begin
                    r_tag[i] <= r_tag[i-1];
                end
            end
        end

        // Response FIFO pointers and occupancy; push and pop may coincide.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == c_PW'(RspDepth - 1)) ? '0 : r_wr_ptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_PW'(RspDepth - 1)) ? '0 : r_rd_ptr + c_PW'(1);
                end
                r_occ <= r_occ + c_CW'(w_push) - c_CW'(w_pop);
            end
        end

        // FIFO storage needs no reset: the output is masked while empty.
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ram_rdata[p];
            end
        end

`ifndef SYNTHESIS
        a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_push && !w_pop && (r_occ == c_CW'(RspDepth))));
        a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (w_used <= c_SW'(RspDepth)));
`endif
    end

    // Address/data follow the request fields; forced to zero during reset.
    assign w_addr_gate = {AddrWidth{rst_ni}};
    assign w_data_gate = {DataWidth{rst_ni}};

    assign req_ready_a_o  = w_ready[0];
    assign req_ready_b_o  = w_ready[1];
    assign ram_rd_en_a_o  = w_rd_issue[0];
    assign ram_rd_en_b_o  = w_rd_issue[1];
    assign ram_wr_en_a_o  = w_wr_issue[0];
    assign ram_wr_en_b_o  = w_wr_issue[1];
    assign ram_addr_r_a_o = req_addr_a_i & w_addr_gate;
    assign ram_addr_w_a_o = req_addr_a_i & w_addr_gate;
    assign ram_addr_r_b_o = req_addr_b_i & w_addr_gate;
    assign ram_addr_w_b_o = req_addr_b_i & w_addr_gate;
    assign ram_wdata_a_o  = req_wdata_a_i & w_data_gate;
    assign ram_wdata_b_o  = req_wdata_b_i & w_data_gate;
    assign rsp_valid_a_o  = w_rsp_valid[0];
    assign rsp_valid_b_o  = w_rsp_valid[1];
    assign rsp_rdata_a_o  = w_rsp_rdata[0];
    assign rsp_rdata_b_o  = w_rsp_rdata[1];

`ifndef SYNTHESIS
    a_no_wr_wr: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ram_wr_en_a_o && ram_wr_en_b_o && (ram_addr_w_a_o == ram_addr_w_b_o)));
    a_no_wr_a_rd_b: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ram_wr_en_a_o && ram_rd_en_b_o && (ram_addr_w_a_o == ram_addr_r_b_o)));
    a_no_rd_a_wr_b: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ram_rd_en_a_o && ram_wr_en_b_o && (ram_addr_r_a_o == ram_addr_w_b_o)));
`endif

endmodule
`default_nettype wire
